goal_player: RTL and testbench

Sequencer and tone synthesizer that plays the goal jingle. It steps a beat index through the combinational beat table (`beatnum` → `tone`, `pmod4`) at a fixed beat rate. It converts the returned frequency into a square wave for the PMOD audio pin, and gates the amplifier enable from the table's `pmod4` flag. It sits between the game FSM, which pulses `start` on a goal, and the audio PMOD.

---
 rtl/goal_player.sv | 106 ++++++++++
 tb/tb_goal_player.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/goal_player.sv
// rtl/goal_player.sv - goal jingle sequencer and square-wave tone synthesizer
module goal_player #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BEAT_TICKS = 25_000_000,
  parameter int NUM_BEATS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  beatnum,
  input  logic [31:0] tone,
  input  logic        pmod4,
  output logic        audio_out,
  output logic        amp_en,
  output logic        busy,
  output logic        done
);

  localparam int            CW        = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(BEAT_TICKS - 1);
  localparam logic [7:0]    LAST_BEAT = 8'(NUM_BEATS - 1);
  localparam logic [33:0]   MODULUS   = 34'(CLK_FREQ);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    beat;
  logic [CW-1:0] cnt;
  logic [33:0]   acc;
  logic          phase;
  logic          beat_end;
  logic          last_beat;
  logic          synth_en;
  logic [33:0]   sum;

  assign beat_end  = (cnt == LAST_TICK);
  assign last_beat = (beat == LAST_BEAT);
  assign synth_en  = (tone != 32'd0) && pmod4;
  // Adding twice the tone gives one phase toggle per half period of the requested frequency.
  assign sum       = acc + {1'b0, tone, 1'b0};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-dependent output gating.
  always_comb begin
    state_next = state;
    beatnum    = 8'hFF;
    audio_out  = 1'b0;
    amp_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = PLAY;
      end
      PLAY: begin
        beatnum   = beat;
        audio_out = phase;
        amp_en    = pmod4;
        busy      = 1'b1;
        if (beat_end && last_beat) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat sequencing and phase accumulator; everything sits at zero outside PLAY so a new play starts clean.
  always_ff @(posedge clk) begin
    if (rst || state != PLAY) begin
      beat  <= 8'd0;
      cnt   <= '0;
      acc   <= 34'd0;
      phase <= 1'b0;
    end else if (beat_end) begin
      // Every beat starts low with an empty accumulator.
      cnt   <= '0;
      acc   <= 34'd0;
      phase <= 1'b0;
      if (!last_beat) beat <= beat + 8'd1;
    end else begin
      cnt <= cnt + 1'b1;
      if (!synth_en) begin
        acc   <= 34'd0;
        phase <= 1'b0;
      end else if (sum >= MODULUS) begin
        acc   <= sum - MODULUS;
        phase <= ~phase;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: tb/tb_goal_player.sv
// tb/tb_goal_player.sv - randomized self-checking bench for goal_player against a beat/toggle model
module tb_goal_player;

  localparam int CF = 1000;
  localparam int BT = 100;
  localparam int NB = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  beatnum;
  logic [31:0] tone;
  logic        pmod4;
  logic        audio_out;
  logic        amp_en;
  logic        busy;
  logic        done;

  int tone_tab[NB];
  bit pm_tab[NB];

  // model state: mode 0 idle, 1 playing, 2 done; beat index and cycle within beat
  int m_mode = 0;
  int m_beat = 0;
  int m_j    = 0;

  int tests = 0;
  int fails = 0;

  goal_player #(.CLK_FREQ(CF), .BEAT_TICKS(BT), .NUM_BEATS(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .beatnum(beatnum), .tone(tone),
    .pmod4(pmod4), .audio_out(audio_out), .amp_en(amp_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // beat table seen by the design
  always_comb begin
    tone  = 32'd0;
    pmod4 = 1'b0;
    if (beatnum < 8'(NB)) begin
      tone  = 32'(tone_tab[beatnum[0]]);
      pmod4 = pm_tab[beatnum[0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase after j accumulation cycles of a beat: number of half periods elapsed, modulo 2.
  function automatic int exp_audio();
    int t;
    t = tone_tab[m_beat];
    if (t == 0 || !pm_tab[m_beat]) return 0;
    return ((m_j * 2 * t) / CF) % 2;
  endfunction

  // One clock: advance the model on the edge with the applied inputs, then compare outputs.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode = 1; m_beat = 0; m_j = 0; end
        1: begin
          if (m_j == BT - 1) begin
            if (m_beat == NB - 1) m_mode = 2;
            else begin m_beat++; m_j = 0; end
          end else begin
            m_j++;
          end
        end
        default: m_mode = 0;
      endcase
    end
    #1;
    check("beatnum", 32'(beatnum), (m_mode == 1) ? 32'(m_beat) : 32'hFF);
    check("busy", 32'(busy), (m_mode == 1) ? 32'd1 : 32'd0);
    check("done", 32'(done), (m_mode == 2) ? 32'd1 : 32'd0);
    check("amp_en", 32'(amp_en), (m_mode == 1) ? 32'(pm_tab[m_beat]) : 32'd0);
    check("audio_out", 32'(audio_out), (m_mode == 1) ? 32'(exp_audio()) : 32'd0);
  endtask

  task automatic set_table(input int t0, input bit p0, input int t1, input bit p1);
    tone_tab[0] = t0; pm_tab[0] = p0;
    tone_tab[1] = t1; pm_tab[1] = p1;
  endtask

  // Pulse start once and track busy length, done position, rises and first rise.
  task automatic play_once(output int busy_n, output int done_at, output int rises, output int first_rise);
    logic prev;
    busy_n = 0; done_at = -1; rises = 0; first_rise = -1; prev = 1'b0;
    start = 1'b1;
    for (int i = 1; i <= 205; i++) begin
      cycle();
      start = 1'b0;
      if (busy) busy_n++;
      if (done && done_at < 0) done_at = i;
      if (audio_out && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = i;
      end
      prev = audio_out;
    end
  endtask

  initial begin
    int bn, da, rs, fr, dn, rst_at;
    rst = 1'b1;
    start = 1'b0;
    set_table(50, 1'b1, 100, 1'b1);
    repeat (3) cycle();
    rst = 1'b0;

    // idle after reset
    repeat (50) cycle();

    // nominal play and waveform
    play_once(bn, da, rs, fr);
    check("busy_len", 32'(bn), 32'd200);
    check("done_cycle", 32'(da), 32'd201);
    check("rises", 32'(rs), 32'd15);
    check("first_rise", 32'(fr), 32'd11);

    // rest on beat 1
    set_table(50, 1'b1, 0, 1'b1);
    play_once(bn, da, rs, fr);
    check("rest_rises", 32'(rs), 32'd5);
    check("rest_busy_len", 32'(bn), 32'd200);
    set_table(50, 1'b1, 100, 1'b1);

    // start held high: back-to-back plays
    start = 1'b1;
    dn = 0;
    for (int i = 0; i < 410; i++) begin
      cycle();
      if (done) dn++;
    end
    check("held_done_count", 32'(dn), 32'd2);
    start = 1'b0;
    repeat (10) cycle();

    // mid-play start pulses ignored
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      start = ($urandom_range(0, 5) == 0) && busy;
      cycle();
    end
    start = 1'b0;
    repeat (5) cycle();

    // reset in beat 1 cycle 37
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 300 && !(m_mode == 1 && m_beat == 1 && m_j == 37); i++) cycle();
    check("reached_beat1_c37", 32'(m_j), 32'd37);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rst_beatnum", 32'(beatnum), 32'hFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (done) dn++;
    end
    check("rst_no_done", 32'(dn), 32'd0);
    play_once(bn, da, rs, fr);
    check("after_rst_busy_len", 32'(bn), 32'd200);
    check("after_rst_done_cycle", 32'(da), 32'd201);

    // randomized tables, gaps, start pulses and resets
    for (int r = 0; r < 10; r++) begin
      set_table(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 499)), 1'($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 499)), 1'($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 5)) cycle();
      rst_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 200)) : -1;
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 1; i < 215; i++) begin
        rst = (i == rst_at);
        start = ($urandom_range(0, 7) == 0);
        cycle();
      end
      rst = 1'b0;
      start = 1'b0;
      // settle to idle before touching the table
      repeat (210) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
